// File: rtl/operand_sequencer.sv
// ============================================================================
// Module: operand_sequencer
//
// Purpose:
//   Upstream feeder for the polynomial datapath/control pair. A single start
//   request latches four operands (A, B, C, X). They are then replayed one at a
//   time on o_data_out, each followed by a go pulse that matches the
//   LOAD/LOAD_WAIT handshake of the downstream FSM. After the last operand the
//   block waits out the downstream compute time and pulses o_done. This lets a
//   bench or top level run a full evaluation without manual key presses.
//
// Timing (start-accept edge = cycle 0):
//   Each operand occupies SETUP_CYCLES + GO_CYCLES + GAP_CYCLES cycles.
//   The first SETUP cycle is cycle 1.
//   o_done is high in cycle 4*P + COMPUTE_CYCLES + 1.
//
// Ports:
//   clk         in   1      system clock, all state on rising edge
//   resetn      in   1      asynchronous, active-low reset
//   i_start     in   1      sequence request, sampled only in IDLE
//   i_op_a      in   WIDTH  operand A, latched when start is accepted
//   i_op_b      in   WIDTH  operand B, latched when start is accepted
//   i_op_c      in   WIDTH  operand C, latched when start is accepted
//   i_op_x      in   WIDTH  operand X, latched when start is accepted
//   o_data_out  out  WIDTH  operand presented downstream
//   o_go        out  1      go level downstream
//   o_busy      out  1      high in every state except IDLE
//   o_done      out  1      single-cycle pulse at sequence completion
// ============================================================================
module operand_sequencer #(
    parameter int WIDTH          = 8,
    parameter int SETUP_CYCLES   = 2,
    parameter int GO_CYCLES      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [WIDTH-1:0] i_op_c,
    input  logic [WIDTH-1:0] i_op_x,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_go,
    output logic             o_busy,
    output logic             o_done
);

    // The shared down-counter only ever holds N-1, so it needs enough bits
    // for the largest phase length minus one.
    localparam int MAX_SG  = (SETUP_CYCLES > GO_CYCLES) ? SETUP_CYCLES : GO_CYCLES;
    localparam int MAX_LC  = (GAP_CYCLES > COMPUTE_CYCLES) ? GAP_CYCLES : COMPUTE_CYCLES;
    localparam int MAX_CYC = (MAX_SG > MAX_LC) ? MAX_SG : MAX_LC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GO_LOAD      = CNT_W'(GO_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] COMPUTE_LOAD = CNT_W'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_GO_HI,
        S_GO_LO,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_idx;
    logic [1:0]         w_next_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               w_latch;
    logic               w_cnt_zero;

    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_op_c;
    logic [WIDTH-1:0]   r_op_x;

    logic [WIDTH-1:0]   r_data_out;
    logic [WIDTH-1:0]   w_next_data;
    logic               r_go;
    logic               r_busy;
    logic               r_done;

    assign w_cnt_zero = (r_cnt == '0);

    // State register, operand index and shared phase counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic. Every timed state loads N-1 into the counter on entry
    // and leaves when the counter reads zero, so a phase of N lasts N cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_latch      = 1'b1;
                    w_next_idx   = 2'd0;
                    w_next_cnt   = SETUP_LOAD;
                    w_next_state = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_next_cnt   = GO_LOAD;
                    w_next_state = S_GO_HI;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end

            S_GO_HI: begin
                if (w_cnt_zero) begin
                    w_next_cnt   = GAP_LOAD;
                    w_next_state = S_GO_LO;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end

            S_GO_LO: begin
                if (w_cnt_zero) begin
                    if (r_idx == 2'd3) begin
                        w_next_cnt   = COMPUTE_LOAD;
                        w_next_state = S_COMPUTE;
                    end else begin
                        w_next_idx   = r_idx + 2'd1;
                        w_next_cnt   = SETUP_LOAD;
                        w_next_state = S_SETUP;
                    end
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end

            S_COMPUTE: begin
                if (w_cnt_zero) begin
                    w_next_cnt   = '0;
                    w_next_state = S_DONE;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end

            S_DONE: begin
                w_next_cnt   = '0;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_idx   = 2'd0;
                w_next_cnt   = '0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand latches are written only on start acceptance, so operand
    // changes while busy cannot reach the replay.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_op_c <= '0;
            r_op_x <= '0;
        end else if (w_latch) begin
            r_op_a <= i_op_a;
            r_op_b <= i_op_b;
            r_op_c <= i_op_c;
            r_op_x <= i_op_x;
        end
    end

    // data_out only changes on entry to SETUP. On acceptance the latches are
    // not yet loaded, so operand A is taken straight from the input; later
    // operands come from the latches. Otherwise the last value is held.
    always_comb begin
        w_next_data = r_data_out;
        if (w_latch) begin
            w_next_data = i_op_a;
        end else if ((r_state == S_GO_LO) && (w_next_state == S_SETUP)) begin
            unique case (w_next_idx)
                2'd0:    w_next_data = r_op_a;
                2'd1:    w_next_data = r_op_b;
                2'd2:    w_next_data = r_op_c;
                default: w_next_data = r_op_x;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any input-to-output combinational path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_out <= '0;
            r_go       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_data_out <= w_next_data;
            r_go       <= (w_next_state == S_GO_HI);
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
        end
    end

    assign o_data_out = r_data_out;
    assign o_go       = r_go;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_operand_sequencer.sv
// ============================================================================
// Module: tb_operand_sequencer
//
// Purpose:
//   Self-checking bench for operand_sequencer. One instance uses the default
//   timing (P = 8, done in cycle 39); a second instance uses all phase lengths
//   equal to 1 (P = 3, done in cycle 14). Each run is traced cycle by cycle
//   against a timing model derived from cycle numbers, with the expected
//   operand order and done cycle supplied by a hand-filled table.
// ============================================================================
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       resetn;

    logic       start;
    logic [7:0] opA, opB, opC, opX;
    logic [7:0] dataOut;
    logic       go, busy, done;

    logic       fStart;
    logic [7:0] fOpA, fOpB, fOpC, fOpX;
    logic [7:0] fDataOut;
    logic       fGo, fBusy, fDone;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    operand_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_start    (start),
        .i_op_a     (opA),
        .i_op_b     (opB),
        .i_op_c     (opC),
        .i_op_x     (opX),
        .o_data_out (dataOut),
        .o_go       (go),
        .o_busy     (busy),
        .o_done     (done)
    );

    operand_sequencer #(
        .WIDTH          (8),
        .SETUP_CYCLES   (1),
        .GO_CYCLES      (1),
        .GAP_CYCLES     (1),
        .COMPUTE_CYCLES (1)
    ) dutFast (
        .clk        (clk),
        .resetn     (resetn),
        .i_start    (fStart),
        .i_op_a     (fOpA),
        .i_op_b     (fOpB),
        .i_op_c     (fOpC),
        .i_op_x     (fOpX),
        .o_data_out (fDataOut),
        .o_go       (fGo),
        .o_busy     (fBusy),
        .o_done     (fDone)
    );

    // One record per default-timing run: inputs, optional stray start pulse,
    // and the hand-computed operand order and done cycle.
    typedef struct {
        logic [7:0] a, b, c, x;
        int         pulseAt;
        logic [7:0] e0, e1, e2, e3;
        int         expDone;
    } run_t;

    run_t runs [4];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic s,
                                 input logic [7:0] a, b, c, x);
        if (sel) begin
            fStart = s; fOpA = a; fOpB = b; fOpC = c; fOpX = x;
        end else begin
            start = s; opA = a; opB = b; opC = c; opX = x;
        end
    endtask

    task automatic setStart(input bit sel, input logic s);
        if (sel) fStart = s;
        else     start  = s;
    endtask

    // Returns {data, go, busy, done} of the selected instance.
    function automatic logic [10:0] sampleOut(input bit sel);
        if (sel) return {fDataOut, fGo, fBusy, fDone};
        return {dataOut, go, busy, done};
    endfunction

    // Drives start with the operands before an edge and consumes that edge,
    // which becomes cycle 0 of the sequence.
    task automatic startSeq(input bit sel, input logic [7:0] a, b, c, x);
        @(negedge clk);
        applyStimulus(sel, 1'b1, a, b, c, x);
        @(posedge clk);
    endtask

    // Called right after the accept edge. Checks cycles 1 .. expDone+1.
    task automatic traceSeq(input bit sel, input int s, g, l,
                            input logic [7:0] e0, e1, e2, e3,
                            input int expDone, input int pulseAt,
                            input bit holdStart, input int changeAt,
                            input logic [7:0] n0, n1, n2, n3,
                            input string tag);
        logic [7:0]  ops [4];
        logic [10:0] smp;
        logic [7:0]  eData, prevData;
        logic        eGo, eBusy, eDone, prevGo;
        int          p, j, r;
        ops[0] = e0; ops[1] = e1; ops[2] = e2; ops[3] = e3;
        p = s + g + l;
        prevGo   = 1'b0;
        prevData = 8'h00;
        for (int k = 1; k <= expDone + 1; k++) begin
            @(negedge clk);
            if (k == changeAt)
                applyStimulus(sel, holdStart, n0, n1, n2, n3);
            setStart(sel, holdStart || (k == pulseAt));
            smp = sampleOut(sel);
            if (k <= 4 * p) begin
                j     = (k - 1) / p;
                r     = (k - 1) % p;
                eData = ops[j];
                eGo   = (r >= s) && (r < s + g);
                eBusy = 1'b1;
            end else begin
                eData = ops[3];
                eGo   = 1'b0;
                eBusy = (k <= expDone);
            end
            eDone = (k == expDone);
            checkOutput($sformatf("%s data c%0d", tag, k), 32'(smp[10:3]), 32'(eData));
            checkOutput($sformatf("%s go c%0d",   tag, k), 32'(smp[2]),    32'(eGo));
            checkOutput($sformatf("%s busy c%0d", tag, k), 32'(smp[1]),    32'(eBusy));
            checkOutput($sformatf("%s done c%0d", tag, k), 32'(smp[0]),    32'(eDone));
            if (k > 1 && !prevGo && smp[2])
                checkOutput($sformatf("%s data stable at go rise c%0d", tag, k),
                            32'(smp[10:3]), 32'(prevData));
            prevGo   = smp[2];
            prevData = smp[10:3];
        end
    endtask

    initial begin
        logic [10:0] smp;

        runs[0] = '{a:8'h01, b:8'h02, c:8'h03, x:8'h04, pulseAt:0,
                    e0:8'h01, e1:8'h02, e2:8'h03, e3:8'h04, expDone:39};
        runs[1] = '{a:8'h01, b:8'h02, c:8'h03, x:8'h04, pulseAt:10,
                    e0:8'h01, e1:8'h02, e2:8'h03, e3:8'h04, expDone:39};
        runs[2] = '{a:8'hFF, b:8'h00, c:8'hA5, x:8'h5A, pulseAt:0,
                    e0:8'hFF, e1:8'h00, e2:8'hA5, e3:8'h5A, expDone:39};
        runs[3] = '{a:8'h80, b:8'h7F, c:8'h01, x:8'hFE, pulseAt:22,
                    e0:8'h80, e1:8'h7F, e2:8'h01, e3:8'hFE, expDone:39};

        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state of both instances.
        #12;
        smp = sampleOut(1'b0);
        checkOutput("reset data", 32'(smp[10:3]), 32'h0);
        checkOutput("reset go",   32'(smp[2]),    32'h0);
        checkOutput("reset busy", 32'(smp[1]),    32'h0);
        checkOutput("reset done", 32'(smp[0]),    32'h0);
        smp = sampleOut(1'b1);
        checkOutput("fast reset data", 32'(smp[10:3]), 32'h0);
        checkOutput("fast reset busy", 32'(smp[1]),    32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven default-timing runs, including stray start pulses.
        for (int i = 0; i < 4; i++) begin
            startSeq(1'b0, runs[i].a, runs[i].b, runs[i].c, runs[i].x);
            traceSeq(1'b0, 2, 4, 2, runs[i].e0, runs[i].e1, runs[i].e2, runs[i].e3,
                     runs[i].expDone, runs[i].pulseAt, 1'b0, 0,
                     8'h00, 8'h00, 8'h00, 8'h00, $sformatf("run%0d", i));
        end

        // start held high; operands change to 5..8 during the first run.
        startSeq(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        traceSeq(1'b0, 2, 4, 2, 8'h01, 8'h02, 8'h03, 8'h04, 39, 0, 1'b1, 5,
                 8'h05, 8'h06, 8'h07, 8'h08, "held1");
        @(posedge clk);
        traceSeq(1'b0, 2, 4, 2, 8'h05, 8'h06, 8'h07, 8'h08, 39, 0, 1'b0, 0,
                 8'h00, 8'h00, 8'h00, 8'h00, "held2");

        // Reset asserted while operand B is in GO_HI (cycle 12).
        startSeq(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            setStart(1'b0, 1'b0);
        end
        smp = sampleOut(1'b0);
        checkOutput("pre-reset go",   32'(smp[2]),    32'h1);
        checkOutput("pre-reset data", 32'(smp[10:3]), 32'h22);
        #2;
        resetn = 1'b0;
        #1;
        smp = sampleOut(1'b0);
        checkOutput("mid reset data", 32'(smp[10:3]), 32'h0);
        checkOutput("mid reset go",   32'(smp[2]),    32'h0);
        checkOutput("mid reset busy", 32'(smp[1]),    32'h0);
        checkOutput("mid reset done", 32'(smp[0]),    32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        smp = sampleOut(1'b0);
        checkOutput("post reset idle busy", 32'(smp[1]), 32'h0);
        startSeq(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        traceSeq(1'b0, 2, 4, 2, 8'h11, 8'h22, 8'h33, 8'h44, 39, 0, 1'b0, 0,
                 8'h00, 8'h00, 8'h00, 8'h00, "after reset");

        // All phase lengths 1: go in cycles 2, 5, 8, 11 and done in cycle 14.
        startSeq(1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
        traceSeq(1'b1, 1, 1, 1, 8'h01, 8'h02, 8'h03, 8'h04, 14, 0, 1'b0, 0,
                 8'h00, 8'h00, 8'h00, 8'h00, "fast");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
